// File: rtl/dispatch_ctrl_n.sv
// Dispatch controller: routes packets to NUM_Q issue queues, allocates tags from a CDB-refilled pool.
// Optional branch stall FSM enabled by DISPATCH_BR_STALL_EN (default build: single resolve tracker, no stall).
//
// state      | meaning
// ST_IDLE    | dispatch allowed
// ST_BR_WAIT | branch dispatched, waiting for its CDB result (stall build only)
// ST_RESOLVE | branch resolved, redirect presented this cycle (stall build only)
module dispatch_ctrl_n #(
  parameter int NUM_Q    = 4,
  parameter int NUM_TAGS = 64,
  parameter int TAG_W    = $clog2(NUM_TAGS),
  parameter int PKT_W    = 96
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_valid,
  input  logic [PKT_W-1:0]              i_pkt,
  input  logic [$clog2(NUM_Q)-1:0]      i_qsel,
  input  logic                          i_need_tag,
  input  logic                          i_is_branch,
  input  logic [31:0]                   i_br_addr,
  input  logic [NUM_Q-1:0]              i_q_full,
  input  logic                          i_cdb_valid,
  input  logic [TAG_W-1:0]              i_cdb_tag,
  input  logic                          i_cdb_branch,
  input  logic                          i_cdb_branch_taken,
  output logic                          o_rd_en,
  output logic [NUM_Q-1:0]              o_q_wen,
  output logic [PKT_W+TAG_W-1:0]        o_q_data,
  output logic [TAG_W-1:0]              o_rd_tag,
  output logic [$clog2(NUM_TAGS+1)-1:0] o_free_tags,
  output logic                          o_redirect,
  output logic [31:0]                   o_redirect_addr
);

  localparam int QSEL_W = $clog2(NUM_Q);
  localparam int CNT_W  = $clog2(NUM_TAGS + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BR_WAIT = 2'd1,
    ST_RESOLVE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   pool_q [NUM_TAGS];
  logic [TAG_W-1:0]   rptr_q, rptr_d;
  logic [TAG_W-1:0]   wptr_q, wptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TAG_W-1:0]   br_tag_q, br_tag_d;
  logic [31:0]        br_addr_q, br_addr_d;
  logic               redir_q, redir_d;
  logic [31:0]        redir_addr_q, redir_addr_d;
`ifndef DISPATCH_BR_STALL_EN
  logic               pend_q, pend_d;
`endif

  logic alloc, sel_full, fire, push, pop, br_match;

  // Out-of-range queue selects read as full so they can never fire.
  always_comb begin
    sel_full = 1'b1;
    for (int q = 0; q < NUM_Q; q++) begin
      if (i_qsel == QSEL_W'(q)) sel_full = i_q_full[q];
    end
    alloc = i_need_tag | i_is_branch;
    fire  = i_valid && (state_q == ST_IDLE) && !sel_full && (!alloc || (cnt_q != '0));
    o_q_wen = '0;
    for (int q = 0; q < NUM_Q; q++) begin
      o_q_wen[q] = fire && (i_qsel == QSEL_W'(q));
    end
    pop    = fire && alloc;
    push   = i_cdb_valid && (cnt_q != CNT_W'(NUM_TAGS));
    rptr_d = rptr_q + TAG_W'(pop);
    wptr_d = wptr_q + TAG_W'(push);
    cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  assign o_rd_en         = fire;
  assign o_rd_tag        = pool_q[rptr_q];
  assign o_q_data        = {i_pkt, o_rd_tag};
  assign o_free_tags     = cnt_q;
  assign o_redirect      = redir_q;
  assign o_redirect_addr = redir_addr_q;

  always_comb begin
    state_d   = state_q;
    br_tag_d  = br_tag_q;
    br_addr_d = br_addr_q;
    br_match  = 1'b0;
`ifdef DISPATCH_BR_STALL_EN
    case (state_q)
      ST_IDLE: begin
        if (fire && i_is_branch) begin
          state_d   = ST_BR_WAIT;
          br_tag_d  = o_rd_tag;
          br_addr_d = i_br_addr;
        end
      end
      ST_BR_WAIT: begin
        br_match = i_cdb_valid && i_cdb_branch && (i_cdb_tag == br_tag_q);
        if (br_match) state_d = ST_RESOLVE;
      end
      ST_RESOLVE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
`else
    pend_d   = pend_q;
    br_match = pend_q && i_cdb_valid && i_cdb_branch && (i_cdb_tag == br_tag_q);
    // A newer branch replaces the tracked one, even if the old one resolves this cycle.
    if (fire && i_is_branch) begin
      pend_d    = 1'b1;
      br_tag_d  = o_rd_tag;
      br_addr_d = i_br_addr;
    end else if (br_match) begin
      pend_d = 1'b0;
    end
    state_d = ST_IDLE;
`endif
    redir_d      = br_match && i_cdb_branch_taken;
    redir_addr_d = redir_d ? br_addr_q : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      rptr_q       <= '0;
      wptr_q       <= '0;
      cnt_q        <= CNT_W'(NUM_TAGS);
      br_tag_q     <= '0;
      br_addr_q    <= '0;
      redir_q      <= 1'b0;
      redir_addr_q <= '0;
`ifndef DISPATCH_BR_STALL_EN
      pend_q       <= 1'b0;
`endif
      for (int i = 0; i < NUM_TAGS; i++) pool_q[i] <= TAG_W'(i);
    end else begin
      state_q      <= state_d;
      rptr_q       <= rptr_d;
      wptr_q       <= wptr_d;
      cnt_q        <= cnt_d;
      br_tag_q     <= br_tag_d;
      br_addr_q    <= br_addr_d;
      redir_q      <= redir_d;
      redir_addr_q <= redir_addr_d;
`ifndef DISPATCH_BR_STALL_EN
      pend_q       <= pend_d;
`endif
      if (push) pool_q[wptr_q] <= i_cdb_tag;
    end
  end

  // Returning a tag into a full pool means upstream double-freed a tag.
  a_no_push_when_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(i_cdb_valid && (cnt_q == CNT_W'(NUM_TAGS))));

endmodule

// File: tb/tb_dispatch_ctrl_n.sv
// Self-checking bench for dispatch_ctrl_n: directed scenarios, then random traffic against a queue-based model.
module tb_dispatch_ctrl_n;
  localparam int NQ = 4;
  localparam int NT = 64;
  localparam int TW = 6;
  localparam int PW = 96;
`ifdef DISPATCH_BR_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic           clk, rst_n;
  logic           valid, need, br, cdb_v, cdb_br, taken;
  logic [PW-1:0]  pkt;
  logic [1:0]     qsel;
  logic [31:0]    br_addr;
  logic [NQ-1:0]  q_full;
  logic [TW-1:0]  cdb_tag;
  logic           o_rd_en, o_redirect;
  logic [NQ-1:0]  o_q_wen;
  logic [PW+TW-1:0] o_q_data;
  logic [TW-1:0]  o_rd_tag;
  logic [6:0]     o_free_tags;
  logic [31:0]    o_redirect_addr;

  dispatch_ctrl_n #(.NUM_Q(NQ), .NUM_TAGS(NT), .PKT_W(PW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_pkt(pkt), .i_qsel(qsel),
    .i_need_tag(need), .i_is_branch(br), .i_br_addr(br_addr), .i_q_full(q_full),
    .i_cdb_valid(cdb_v), .i_cdb_tag(cdb_tag), .i_cdb_branch(cdb_br),
    .i_cdb_branch_taken(taken), .o_rd_en(o_rd_en), .o_q_wen(o_q_wen),
    .o_q_data(o_q_data), .o_rd_tag(o_rd_tag), .o_free_tags(o_free_tags),
    .o_redirect(o_redirect), .o_redirect_addr(o_redirect_addr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: free tags as a FIFO queue, tags in flight as a list, plus branch bookkeeping.
  int          fq[$];
  int          outst[$];
  bit          br_pend, resolve_now, exp_redir;
  int          br_tag_m;
  logic [31:0] br_addr_m, exp_raddr;
  int          n_cmp, n_bad;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_init();
    fq.delete();
    for (int i = 0; i < NT; i++) fq.push_back(i);
    outst.delete();
    br_pend = 0; resolve_now = 0; exp_redir = 0;
    br_tag_m = -1; br_addr_m = '0; exp_raddr = '0;
  endtask

  task automatic idle_inputs();
    valid = 0; need = 0; br = 0; cdb_v = 0; cdb_br = 0; taken = 0;
    pkt = '0; qsel = '0; br_addr = '0; q_full = '0; cdb_tag = '0;
  endtask

  // Called just after a falling edge with inputs set; checks, then advances the model over the rising edge.
  task automatic step();
    bit alloc, busy, f, match;
    int tag;
    #2;
    alloc = need | br;
    busy  = STALL && (br_pend || resolve_now);
    f     = valid && !busy && !q_full[qsel] && (!alloc || fq.size() > 0);
    chk("rd_en", o_rd_en, f);
    chk("q_wen", o_q_wen, f ? (4'b0001 << qsel) : 4'b0000);
    chk("free_tags", o_free_tags, fq.size());
    if (fq.size() > 0) chk("rd_tag", o_rd_tag, fq[0]);
    if (f && fq.size() > 0) chk("q_data", o_q_data, {pkt, TW'(fq[0])});
    chk("redirect", o_redirect, exp_redir);
    chk("redir_addr", o_redirect_addr, exp_raddr);
    @(posedge clk);
    tag = (fq.size() > 0) ? fq[0] : -1;
    if (f && alloc) begin
      void'(fq.pop_front());
      outst.push_back(tag);
    end
    if (cdb_v) begin
      if (fq.size() < NT) fq.push_back(int'(cdb_tag));
      for (int i = 0; i < outst.size(); i++)
        if (outst[i] == int'(cdb_tag)) begin outst.delete(i); break; end
    end
    match     = cdb_v && cdb_br && br_pend && (int'(cdb_tag) == br_tag_m);
    exp_redir = match && taken;
    exp_raddr = (match && taken) ? br_addr_m : '0;
    resolve_now = STALL && match;
    if (f && br) begin
      br_pend = 1; br_tag_m = tag; br_addr_m = br_addr;
    end else if (match) begin
      br_pend = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    rst_n = 1;
    model_init();
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic dispatch_plain(input int n);
    for (int i = 0; i < n; i++) begin
      idle_inputs(); valid = 1; need = 1; qsel = 2'(i); pkt = PW'($urandom);
      step();
    end
    idle_inputs();
  endtask

  task automatic branch_case(input bit tk, input logic [31:0] addr);
    do_reset();
    dispatch_plain(7);
    valid = 1; br = 1; br_addr = addr; qsel = 1; pkt = PW'(32'hB0B0);
    #1 chk("br_tag7", o_q_data[TW-1:0], 7);
    step();                                             // N
    idle_inputs(); valid = 1; qsel = 3;
    if (!tk) begin cdb_v = 1; cdb_tag = 7; cdb_br = 0; end
    step();                                             // N+1
    idle_inputs(); valid = 1; qsel = 3;
    #1 chk("br_no_early_redir", o_redirect, 0);
    step();                                             // N+2
    cdb_v = 1; cdb_tag = 7; cdb_br = 1; taken = tk;
    step();                                             // N+3
    idle_inputs(); valid = 1; qsel = 3;
    #1 chk("br_redir_n4", o_redirect, tk);
    chk("br_addr_n4", o_redirect_addr, tk ? addr : 32'h0);
    chk("br_bubble_n4", o_rd_en, !STALL);
    step();                                             // N+4
    #1 chk("br_resume_n5", o_rd_en, 1);
    chk("br_pulse_once", o_redirect, 0);
    step();                                             // N+5
    idle_inputs();
  endtask

  initial begin
    int idx, t;
    n_cmp = 0; n_bad = 0;
    idle_inputs();
    rst_n = 0;
    model_init();
    @(negedge clk);
    #1;
    chk("rst_free", o_free_tags, 64);
    chk("rst_tag", o_rd_tag, 0);
    chk("rst_redir", o_redirect, 0);
    chk("rst_raddr", o_redirect_addr, 0);
    chk("rst_rd_en", o_rd_en, 0);
    chk("rst_wen", o_q_wen, 0);
    rst_n = 1;
    @(negedge clk);

    // Four dispatches to queues 0..3.
    for (int i = 0; i < 4; i++) begin
      valid = 1; need = 1; qsel = 2'(i); pkt = PW'($urandom);
      #1 chk("a_wen", o_q_wen, 4'b0001 << i);
      chk("a_tag", o_q_data[TW-1:0], i);
      step();
    end
    idle_inputs();
    #1 chk("a_free60", o_free_tags, 60);

    // Target queue full blocks, release dispatches in the same cycle.
    valid = 1; need = 1; qsel = 2; q_full = 4'b0100;
    #1 chk("b_blocked", o_rd_en, 0);
    step();
    chk("b_pool_same", o_free_tags, 60);
    q_full = 4'b0000;
    #1 chk("b_release", o_rd_en, 1);
    step();
    idle_inputs();

    branch_case(1'b1, 32'h100);
    branch_case(1'b0, 32'h200);

    // Reset while waiting on a branch, then while a redirect is being presented.
    do_reset();
    valid = 1; br = 1; br_addr = 32'h300; step();
    idle_inputs(); step();
    valid = 1; need = 1; qsel = 1; rst_n = 0;
    #1 chk("e_free", o_free_tags, 64);
    chk("e_redir", o_redirect, 0);
    chk("e_idle_fire", o_rd_en, 1);
    chk("e_tag0", o_rd_tag, 0);
    do_reset();
    valid = 1; br = 1; br_addr = 32'h400; step();
    idle_inputs(); cdb_v = 1; cdb_tag = 0; cdb_br = 1; taken = 1; step();
    idle_inputs();
    #1 chk("e2_redir_pre", o_redirect, 1);
    rst_n = 0;
    #1 chk("e2_redir_clr", o_redirect, 0);
    chk("e2_raddr_clr", o_redirect_addr, 0);
    chk("e2_free", o_free_tags, 64);
    do_reset();

    // Exhaustion, refill and simultaneous push/pop.
    dispatch_plain(64);
    #1 chk("f_free0", o_free_tags, 0);
    valid = 1; need = 1; qsel = 0; cdb_v = 1; cdb_tag = 5;
    #1 chk("f_blocked", o_rd_en, 0);
    step();
    idle_inputs(); valid = 1; need = 1; qsel = 1;
    #1 chk("f_tag5", o_q_data[TW-1:0], 5);
    step();
    idle_inputs(); cdb_v = 1; cdb_tag = 9; step();
    idle_inputs(); valid = 1; need = 1; qsel = 2; cdb_v = 1; cdb_tag = 11;
    #1 chk("f_tag9", o_q_data[TW-1:0], 9);
    step();
    idle_inputs();
    #1 chk("f_cnt1", o_free_tags, 1);
    chk("f_tag11", o_rd_tag, 11);

    // Random traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      valid   = ($urandom % 4) != 0;
      qsel    = 2'($urandom);
      need    = $urandom % 2;
      br      = ($urandom % 6) == 0;
      br_addr = $urandom;
      pkt     = {$urandom, $urandom, $urandom};
      q_full  = 4'($urandom & $urandom & $urandom);
      if (outst.size() > 0 && ($urandom % 2)) begin
        idx     = $urandom_range(outst.size() - 1, 0);
        t       = outst[idx];
        cdb_v   = 1;
        cdb_tag = TW'(t);
        cdb_br  = (br_pend && t == br_tag_m) ? 1'b1 : (($urandom % 4) == 0);
        taken   = $urandom % 2;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dispatch_ctrl_n.md
# dispatch_ctrl_n

Parametrised dispatch controller that sits between the fetch queue and the execution issue queues. It routes each decoded packet to one of `NUM_Q` issue queues and allocates the destination tag from a free-tag pool that is refilled from the CDB. It also holds a branch-stall state machine that stops dispatch behind an unresolved branch and issues a fetch redirect on a taken branch. It generalises the fixed four-queue dispatch path: queue count, tag space and packet width are configurable, and tag recycling and branch handling are added.

## Interface
- `NUM_Q`, default 4: number of issue queues (≥2).
- `NUM_TAGS`, default 64: tag pool depth; power of 2.
- `TAG_W`, default `$clog2(NUM_TAGS)`: tag width.
- `PKT_W`, default 96: dispatch packet width, excluding tag.
- `i_clk`, in, 1: clock, rising edge.
- `i_rst_n`, in, 1: reset, asynchronous, active-low.
- `i_valid`, in, 1: fetch queue not empty.
- `i_pkt`, in, `PKT_W`: decoded packet.
- `i_qsel`, in, `$clog2(NUM_Q)`: target queue index.
- `i_need_tag`, in, 1: instruction writes rd.
- `i_is_branch`, in, 1: conditional branch.
- `i_br_addr`, in, 32: branch target.
- `i_q_full`, in, `NUM_Q`: per-queue full flags.
- `i_cdb_valid`, in, 1: CDB broadcast valid.
- `i_cdb_tag`, in, `TAG_W`: CDB tag.
- `i_cdb_branch`, in, 1: CDB carries a branch result.
- `i_cdb_branch_taken`, in, 1: branch outcome.
- `o_rd_en`, out, 1: pop the fetch queue; equals dispatch fire.
- `o_q_wen`, out, `NUM_Q`: one-hot issue-queue write enable.
- `o_q_data`, out, `PKT_W+TAG_W`: `{i_pkt, o_rd_tag}`.
- `o_rd_tag`, out, `TAG_W`: tag at the head of the pool.
- `o_free_tags`, out, `$clog2(NUM_TAGS+1)`: number of free tags.
- `o_redirect`, out, 1: taken-branch redirect pulse.
- `o_redirect_addr`, out, 32: redirect target.

## Operation
- Tag allocation:
  - `alloc = i_need_tag | i_is_branch`.
  - A branch always takes a tag, because its result returns on the CDB.
- Dispatch fire (combinational): `fire = i_valid & state==IDLE & ~i_q_full[i_qsel] & (~alloc | o_free_tags!=0)`.
- Write enable: `o_q_wen = fire ? (1<<i_qsel) : 0`. `o_rd_en = fire`.
- Tag pool:
  - Circular FIFO of depth `NUM_TAGS`, with read pointer, write pointer and count.
  - Reset contents are 0..`NUM_TAGS`-1 in order, with count `NUM_TAGS`.
  - Pop on `fire & alloc`.
  - Push `i_cdb_tag` on `i_cdb_valid`.
  - Simultaneous push and pop:
    - Both pointers advance and count is unchanged.
    - A tag pushed this cycle is never bypassed to `o_rd_tag`.
  - Push while count==`NUM_TAGS` is a protocol error: the push is ignored and a simulation assertion fires.
  - Pointers wrap modulo `NUM_TAGS`.
- Branch FSM has three states: IDLE, BR_WAIT, RESOLVE.
  - IDLE → BR_WAIT on `fire & i_is_branch`. The dispatched tag is latched to `br_tag` and `i_br_addr` to `br_addr_q`.
  - BR_WAIT → RESOLVE on `i_cdb_valid & i_cdb_branch & i_cdb_tag==br_tag`. The outcome is latched.
  - RESOLVE → IDLE unconditionally.
  - In RESOLVE, `o_redirect` = latched taken and `o_redirect_addr` = `br_addr_q`.
  - No dispatch occurs in BR_WAIT or RESOLVE.
  - A CDB broadcast with a non-matching tag, or with `i_cdb_branch`=0, does not change the state. Its tag is still returned to the pool.

## Timing
- Reset values:
  - State IDLE, `o_redirect`=0, `o_redirect_addr`=0.
  - `o_free_tags`=`NUM_TAGS`, `o_rd_tag`=0.
  - `o_q_wen`=0 and `o_rd_en`=0 while `i_valid`=0.
- Dispatch latency: fire, `o_q_wen` and `o_q_data` are combinational in the same cycle. The pool pointer updates at the next edge.
- Branch bubble:
  - Branch dispatched in cycle N.
  - CDB match in cycle M ≥ N+1.
  - RESOLVE in M+1, with `o_redirect` high for exactly that one cycle if taken.
  - Next dispatch possible in M+2.
- A CDB match in the same cycle as the branch dispatch is impossible, because the tag is not yet broadcast.
- Asserting `i_rst_n` mid-operation:
  - Aborts BR_WAIT and RESOLVE immediately.
  - Reinitialises the pool and clears `o_redirect` asynchronously.

## Configuration
- `DISPATCH_BR_STALL_EN` defined: the branch FSM operates as specified above.
- `DISPATCH_BR_STALL_EN` undefined:
  - The FSM stays in IDLE and branches dispatch back-to-back.
  - Only a single resolve tracker is kept: `o_redirect` pulses one cycle after a matching CDB branch broadcast that is taken. The tracker latches the tag and address of the most recent branch.
  - Upstream is responsible for squashing.

## Test plan
- Reset, then 4 dispatches with `i_need_tag`=1 and `i_qsel`=0..3 → `o_q_wen` = 1, 2, 4, 8; tags 0, 1, 2, 3; `o_free_tags`=60.
- `i_q_full`=4'b0100 with `i_qsel`=2 and `i_valid`=1 → `o_rd_en`=0 and the pool is unchanged; releasing full dispatches in that cycle.
- Exhaustion (`NUM_TAGS`=64):
  - Allocate 64 tags → `o_free_tags`=0 and fire is blocked.
  - CDB returns tag 5 → next dispatch gets tag 5.
  - Simultaneous push and pop at count 1 keeps count at 1.
- Branch with tag 7 and `i_br_addr`=0x100, CDB tag 7 taken in cycle N+3 → `o_redirect`=1 with addr 0x100 in N+4; dispatch resumes in N+5.
- Same branch not taken → `o_redirect` stays 0 and the bubble is identical. A non-branch CDB broadcast of tag 7 does not resolve it.
- Assert `i_rst_n` during BR_WAIT → state IDLE, `o_free_tags`=64 and `o_redirect`=0 without waiting for a clock.
